// File: rtl/control_unit_pkg.sv
// Shared RV32I decode constants: opcodes, funct3/funct7 values, ALU op codes,
// mux-select encodings and the registered control word.
package control_unit_pkg;

  localparam logic [6:0] R_OPCODE     = 7'b0110011;
  localparam logic [6:0] I_OPCODE     = 7'b0010011;
  localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
  localparam logic [6:0] S_OPCODE     = 7'b0100011;
  localparam logic [6:0] B_OPCODE     = 7'b1100011;
  localparam logic [6:0] JAL_OPCODE   = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE  = 7'b1100111;
  localparam logic [6:0] LUI_OPCODE   = 7'b0110111;
  localparam logic [6:0] AUIPC_OPCODE = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [2:0] FUNCT3_JALR = 3'b000;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_SLL = 4'h2, ALU_SLT = 4'h3,
    ALU_SLTU = 4'h4, ALU_XOR  = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7,
    ALU_OR   = 4'h8, ALU_AND  = 4'h9, ALU_EQ  = 4'hA, ALU_NE  = 4'hB,
    ALU_LT   = 4'hC, ALU_GE   = 4'hD, ALU_LTU = 4'hE, ALU_GEU = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    RF_SEL_ALU  = 2'b00,
    RF_SEL_DMEM = 2'b01,
    RF_SEL_PC4  = 2'b10,
    RF_SEL_UIMM = 2'b11
  } rf_sel_e;

  typedef enum logic [1:0] {
    MUX2_RS2 = 2'b00,
    MUX2_IMM = 2'b01
  } mux2_sel_e;

  localparam logic MUX1_RS1     = 1'b0;
  localparam logic MUX1_PC      = 1'b1;
  localparam logic PC_SEL_ADDER = 1'b0;
  localparam logic PC_SEL_ALU   = 1'b1;

  typedef struct packed {
    rf_sel_e    rf_w_select;
    logic       alu_mux1_select;
    mux2_sel_e  alu_mux2_select;
    alu_op_e    alu_op_select;
    logic       alu_pc_select;
    logic       w_en_rf;
    logic       w_en_pmem;
    logic       wr_en_dmem;
    logic [1:0] rw_mode;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Arithmetic op shared by R and I-ALU; alt selects SUB/SRA.
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      FUNCT3_ADD_SUB: arith_op = alt ? ALU_SUB : ALU_ADD;
      FUNCT3_SLL:     arith_op = ALU_SLL;
      FUNCT3_SLT:     arith_op = ALU_SLT;
      FUNCT3_SLTU:    arith_op = ALU_SLTU;
      FUNCT3_XOR:     arith_op = ALU_XOR;
      FUNCT3_SRL_SRA: arith_op = alt ? ALU_SRA : ALU_SRL;
      FUNCT3_OR:      arith_op = ALU_OR;
      default:        arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-in / control-word-out bundle between fetch, decoder and datapath.
// No handshake: instr is sampled every rising edge, controls are valid one edge later.
interface control_unit_if;
  logic [31:0] instr;
  logic [1:0]  rf_w_select;
  logic        alu_mux1_select;
  logic [1:0]  alu_mux2_select;
  logic [3:0]  alu_op_select;
  logic        alu_pc_select;
  logic        w_en_rf;
  logic        w_en_pmem;
  logic        wr_en_dmem;
  logic [1:0]  rw_mode;
  logic        branch;
  logic        jump;

  modport master (
    output instr,
    input  rf_w_select, alu_mux1_select, alu_mux2_select, alu_op_select,
           alu_pc_select, w_en_rf, w_en_pmem, wr_en_dmem, rw_mode, branch, jump
  );

  modport slave (
    input  instr,
    output rf_w_select, alu_mux1_select, alu_mux2_select, alu_op_select,
           alu_pc_select, w_en_rf, w_en_pmem, wr_en_dmem, rw_mode, branch, jump
  );
endinterface

// File: rtl/control_unit_decoder.sv
// Combinational RV32I decode: instruction word to next control word.
// Any unrecognised encoding yields an all-zero word, which also stalls the PC.
module control_decoder
  import control_unit_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       valid;
  ctrl_t      c;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    c     = '0;
    valid = 1'b0;
    case (opcode)
      R_OPCODE: begin
        valid = (funct7 == FUNCT7_BASE) ||
                ((funct7 == FUNCT7_ALT) &&
                 (funct3 == FUNCT3_ADD_SUB || funct3 == FUNCT3_SRL_SRA));
        c.alu_mux1_select = MUX1_RS1;
        c.alu_mux2_select = MUX2_RS2;
        c.alu_op_select   = arith_op(funct3, funct7[5]);
        c.rf_w_select     = RF_SEL_ALU;
        c.w_en_rf         = 1'b1;
      end
      I_OPCODE: begin
        // Only the shift-immediates carry a funct7; ADDI etc. use those bits as immediate.
        case (funct3)
          FUNCT3_SLL:     valid = (funct7 == FUNCT7_BASE);
          FUNCT3_SRL_SRA: valid = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          default:        valid = 1'b1;
        endcase
        c.alu_mux1_select = MUX1_RS1;
        c.alu_mux2_select = MUX2_IMM;
        c.alu_op_select   = arith_op(funct3, (funct3 == FUNCT3_SRL_SRA) && funct7[5]);
        c.rf_w_select     = RF_SEL_ALU;
        c.w_en_rf         = 1'b1;
      end
      LOAD_OPCODE: begin
        valid = funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
        c.alu_op_select   = ALU_ADD;
        c.alu_mux2_select = MUX2_IMM;
        c.rf_w_select     = RF_SEL_DMEM;
        c.w_en_rf         = 1'b1;
        c.rw_mode         = funct3[1:0];
      end
      S_OPCODE: begin
        valid = funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
        c.alu_op_select   = ALU_ADD;
        c.alu_mux2_select = MUX2_IMM;
        c.wr_en_dmem      = 1'b1;
        c.rw_mode         = funct3[1:0];
      end
      B_OPCODE: begin
        valid = 1'b1;
        case (funct3)
          FUNCT3_BEQ:  c.alu_op_select = ALU_EQ;
          FUNCT3_BNE:  c.alu_op_select = ALU_NE;
          FUNCT3_BLT:  c.alu_op_select = ALU_LT;
          FUNCT3_BGE:  c.alu_op_select = ALU_GE;
          FUNCT3_BLTU: c.alu_op_select = ALU_LTU;
          FUNCT3_BGEU: c.alu_op_select = ALU_GEU;
          default:     valid = 1'b0;
        endcase
        c.alu_mux2_select = MUX2_RS2;
        c.alu_pc_select   = PC_SEL_ADDER;
        c.branch          = 1'b1;
      end
      JAL_OPCODE: begin
        valid = 1'b1;
        c.jump          = 1'b1;
        c.alu_pc_select = PC_SEL_ADDER;
        c.rf_w_select   = RF_SEL_PC4;
        c.w_en_rf       = 1'b1;
      end
      JALR_OPCODE: begin
        valid = (funct3 == FUNCT3_JALR);
        c.alu_op_select   = ALU_ADD;
        c.alu_mux1_select = MUX1_RS1;
        c.alu_mux2_select = MUX2_IMM;
        c.jump            = 1'b1;
        c.alu_pc_select   = PC_SEL_ALU;
        c.rf_w_select     = RF_SEL_PC4;
        c.w_en_rf         = 1'b1;
      end
      LUI_OPCODE: begin
        valid = 1'b1;
        c.rf_w_select = RF_SEL_UIMM;
        c.w_en_rf     = 1'b1;
      end
      AUIPC_OPCODE: begin
        valid = 1'b1;
        c.alu_op_select   = ALU_ADD;
        c.alu_mux1_select = MUX1_PC;
        c.alu_mux2_select = MUX2_IMM;
        c.rf_w_select     = RF_SEL_ALU;
        c.w_en_rf         = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    c.w_en_pmem = 1'b1;
    if (!valid) c = '0;
  end

  assign ctrl = c;

endmodule

// File: rtl/control_unit.sv
// Registered RV32I control unit: decodes instr combinationally and
// presents the control word one rising edge later.
module control_unit
  import control_unit_pkg::*;
(
  input logic           clk,
  input logic           rst,
  control_unit_if.slave bus
);

  ctrl_t next_ctrl;
  ctrl_t ctrl_q;

  control_decoder u_decoder (
    .instr (bus.instr),
    .ctrl  (next_ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= next_ctrl;
  end

  assign bus.rf_w_select     = ctrl_q.rf_w_select;
  assign bus.alu_mux1_select = ctrl_q.alu_mux1_select;
  assign bus.alu_mux2_select = ctrl_q.alu_mux2_select;
  assign bus.alu_op_select   = ctrl_q.alu_op_select;
  assign bus.alu_pc_select   = ctrl_q.alu_pc_select;
  assign bus.w_en_rf         = ctrl_q.w_en_rf;
  assign bus.w_en_pmem       = ctrl_q.w_en_pmem;
  assign bus.wr_en_dmem      = ctrl_q.wr_en_dmem;
  assign bus.rw_mode         = ctrl_q.rw_mode;
  assign bus.branch          = ctrl_q.branch;
  assign bus.jump            = ctrl_q.jump;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a table of instruction words with hand-computed
// control words, plus reset, hold and async-reset sequences.
module tb_control_unit;

  logic clk;
  logic rst;

  control_unit_if bus();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // observed control word, same field order as cw()
  logic [16:0] act;
  assign act = {bus.rf_w_select, bus.alu_mux1_select, bus.alu_mux2_select,
                bus.alu_op_select, bus.alu_pc_select, bus.w_en_rf, bus.w_en_pmem,
                bus.wr_en_dmem, bus.rw_mode, bus.branch, bus.jump};

  function automatic logic [16:0] cw(input logic [1:0] rf, input logic m1,
                                     input logic [1:0] m2, input logic [3:0] op,
                                     input logic pcs, input logic wrf, input logic wpm,
                                     input logic wdm, input logic [1:0] rw,
                                     input logic br, input logic j);
    return {rf, m1, m2, op, pcs, wrf, wpm, wdm, rw, br, j};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [16:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic add(input string name, input logic [31:0] instr, input logic [16:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.exp = exp;
    vecs.push_back(v);
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [16:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h (%b) expected %05h (%b)", name, act, act, exp, exp);
  endtask

  // driver: apply at negedge, compare just after the following rising edge
  task automatic drive_and_check(input string name, input logic [31:0] instr,
                                 input logic [16:0] exp);
    @(negedge clk);
    bus.instr = instr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name, exp_q.pop_front());
  endtask

  localparam logic [31:0] I_ADD = 32'h00418133;
  localparam logic [31:0] I_LUI = 32'h00002537;
  localparam logic [31:0] I_JAL = 32'h050001EF;

  initial begin
    //            rf m1 m2 op  pcs wrf wpm wdm rw br j
    add("add",    I_ADD,        cw(0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    add("sub",    32'h40418133, cw(0, 0, 0, 4'h1, 0, 1, 1, 0, 0, 0, 0));
    add("slt",    32'h00002033, cw(0, 0, 0, 4'h3, 0, 1, 1, 0, 0, 0, 0));
    add("sltu",   32'h00003033, cw(0, 0, 0, 4'h4, 0, 1, 1, 0, 0, 0, 0));
    add("xor",    32'h00004033, cw(0, 0, 0, 4'h5, 0, 1, 1, 0, 0, 0, 0));
    add("sra",    32'h40005033, cw(0, 0, 0, 4'h7, 0, 1, 1, 0, 0, 0, 0));
    add("and",    32'h00007033, cw(0, 0, 0, 4'h9, 0, 1, 1, 0, 0, 0, 0));
    add("r_badf7",32'h40001033, 17'h0);
    add("addi",   32'h00418113, cw(0, 0, 1, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    add("ori",    32'h00006013, cw(0, 0, 1, 4'h8, 0, 1, 1, 0, 0, 0, 0));
    add("srai",   32'h40005013, cw(0, 0, 1, 4'h7, 0, 1, 1, 0, 0, 0, 0));
    add("srli_bad",32'h02005013, 17'h0);
    add("lw",     32'h00822183, cw(1, 0, 1, 4'h0, 0, 1, 1, 0, 2, 0, 0));
    add("lbu",    32'h00004003, cw(1, 0, 1, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    add("lhu",    32'h00005003, cw(1, 0, 1, 4'h0, 0, 1, 1, 0, 1, 0, 0));
    add("ld_bad", 32'h00003003, 17'h0);
    add("sw",     32'h0041A623, cw(0, 0, 1, 4'h0, 0, 0, 1, 1, 2, 0, 0));
    add("sb",     32'h00000023, cw(0, 0, 1, 4'h0, 0, 0, 1, 1, 0, 0, 0));
    add("sh",     32'h00001023, cw(0, 0, 1, 4'h0, 0, 0, 1, 1, 1, 0, 0));
    add("st_bad", 32'h00003023, 17'h0);
    add("beq",    32'h00000063, cw(0, 0, 0, 4'hA, 0, 0, 1, 0, 0, 1, 0));
    add("bne",    32'h00001063, cw(0, 0, 0, 4'hB, 0, 0, 1, 0, 0, 1, 0));
    add("blt",    32'h00004063, cw(0, 0, 0, 4'hC, 0, 0, 1, 0, 0, 1, 0));
    add("bge",    32'h0041D663, cw(0, 0, 0, 4'hD, 0, 0, 1, 0, 0, 1, 0));
    add("bltu",   32'h00006063, cw(0, 0, 0, 4'hE, 0, 0, 1, 0, 0, 1, 0));
    add("bgeu",   32'h00007063, cw(0, 0, 0, 4'hF, 0, 0, 1, 0, 0, 1, 0));
    add("br_bad", 32'h00002063, 17'h0);
    add("jal",    I_JAL,        cw(2, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 1));
    add("jalr",   32'h078201E7, cw(2, 0, 1, 4'h0, 1, 1, 1, 0, 0, 0, 1));
    add("jalr_bad",32'h00001067, 17'h0);
    add("lui",    I_LUI,        cw(3, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    add("auipc",  32'h00002797, cw(0, 1, 1, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    add("zero",   32'h00000000, 17'h0);
    add("fence",  32'h0000000F, 17'h0);
    add("ecall",  32'h00000073, 17'h0);
    add("low_bits",32'h00418131, 17'h0);

    // reset with a valid instruction present: outputs stay 0 across edges
    rst = 1'b0;
    bus.instr = I_ADD;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset", 17'h0);

    // first edge after release decodes the instruction already on the bus
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("first_after_release", cw(0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      drive_and_check(vecs[i].name, vecs[i].instr, vecs[i].exp);

    // instr change between edges must not reach the outputs
    drive_and_check("hold_setup", I_ADD, cw(0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    #2 bus.instr = I_LUI;
    #2 check("hold_no_edge", cw(0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1 check("hold_next_edge", cw(3, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0));

    // asynchronous reset mid-stream clears outputs before any edge
    @(negedge clk);
    rst = 1'b1;
    #1 check("async_reset", 17'h0);
    @(posedge clk);
    #1 check("reset_held", 17'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.instr = I_JAL;
    #1 check("release_no_edge", 17'h0);
    @(posedge clk);
    #1 check("after_async_release", cw(2, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
